// File: rtl/sync_fifo_flags.sv
// -----------------------------------------------------------------------------
// sync_fifo_flags
//
// Single-clock FIFO with an occupancy count, programmable almost-full and
// almost-empty thresholds, and sticky overflow/underflow error flags.
//
// Optional feature: define FIFO_FWFT_EN for first-word-fall-through reads.
//   - With FIFO_FWFT_EN, dout shows the head entry combinationally.
//   - Without it, dout is a register loaded on each accepted read.
//
// Parameters:
//   WIDTH          data width in bits (>= 1)
//   DEPTH          number of entries, power of two (>= 2)
//   AFULL_THRESH   almost_full  when count >= AFULL_THRESH  (1..DEPTH)
//   AEMPTY_THRESH  almost_empty when count <= AEMPTY_THRESH (0..DEPTH-1)
//
// Ports:
//   clk           clock, all state changes on posedge
//   rst           asynchronous active-high reset
//   wr_en, din    write request and data
//   rd_en, dout   read request and data
//   full, empty, almost_full, almost_empty   decodes of count
//   count         occupancy, 0..DEPTH
//   overflow      sticky: write attempted while full
//   underflow     sticky: read attempted while empty
//   clr_err       synchronous clear of overflow/underflow
//
// Handshake:
//   - wr_en acts as a valid and !full as its ready; a write is accepted
//     only when both are high in the same cycle.
//   - rd_en acts as a valid and !empty as its ready; a read is accepted
//     only when both are high in the same cycle.
//   - Both readies come from the registered count, so they never depend
//     combinationally on wr_en or rd_en.
// -----------------------------------------------------------------------------
module sync_fifo_flags #(
   parameter int WIDTH         = 8,
   parameter int DEPTH         = 16,
   parameter int AFULL_THRESH  = DEPTH - 2,
   parameter int AEMPTY_THRESH = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_en,
   input  logic [WIDTH-1:0]         din,
   input  logic                     rd_en,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic                     almost_full,
   output logic                     almost_empty,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow,
   output logic                     underflow,
   input  logic                     clr_err
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wptr;
   logic [AW-1:0]    r_rptr;
   logic [CW-1:0]    r_count;
   logic             r_overflow;
   logic             r_underflow;

   logic             w_full;
   logic             w_empty;
   logic             w_wr_acc;
   logic             w_rd_acc;

   // All status flags decode the count register only, so they change
   // exclusively on clock edges.
   assign w_full       = (r_count == CW'(DEPTH));
   assign w_empty      = (r_count == '0);
   assign full         = w_full;
   assign empty        = w_empty;
   assign almost_full  = (r_count >= CW'(AFULL_THRESH));
   assign almost_empty = (r_count <= CW'(AEMPTY_THRESH));
   assign count        = r_count;
   assign overflow     = r_overflow;
   assign underflow    = r_underflow;

   // Acceptance looks at this cycle's full/empty: a read in the same cycle
   // does not make room for a write, and a write does not feed a read.
   assign w_wr_acc = wr_en && !w_full;
   assign w_rd_acc = rd_en && !w_empty;

   // Storage is deliberately not reset.
   always_ff @(posedge clk) begin
      if (w_wr_acc) begin
         r_mem[r_wptr] <= din;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wptr      <= '0;
         r_rptr      <= '0;
         r_count     <= '0;
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         // Pointers are exactly AW bits wide, so DEPTH-1 -> 0 wraps for free.
         if (w_wr_acc) begin
            r_wptr <= r_wptr + 1'b1;
         end
         if (w_rd_acc) begin
            r_rptr <= r_rptr + 1'b1;
         end

         case ({w_wr_acc, w_rd_acc})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase

         // A new error event takes priority over a coincident clear.
         if (wr_en && w_full) begin
            r_overflow <= 1'b1;
         end else if (clr_err) begin
            r_overflow <= 1'b0;
         end

         if (rd_en && w_empty) begin
            r_underflow <= 1'b1;
         end else if (clr_err) begin
            r_underflow <= 1'b0;
         end
      end
   end

`ifdef FIFO_FWFT_EN
   // Head entry is always presented; an accepted read pops the word shown.
   // The value is meaningless while empty.
   assign dout = r_mem[r_rptr];
`else
   logic [WIDTH-1:0] r_dout;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_dout <= '0;
      end else if (w_rd_acc) begin
         r_dout <= r_mem[r_rptr];
      end
   end

   assign dout = r_dout;
`endif

endmodule

// File: tb/tb_sync_fifo_flags.sv
// -----------------------------------------------------------------------------
// tb_sync_fifo_flags
//
// Bench for sync_fifo_flags (default parameters: WIDTH=8, DEPTH=16).
// The reference model is a data queue plus two error bits, updated from the
// FIFO rules on every rising edge. Read data is pushed into exp_q when the
// model accepts a read, and a separate monitor pops and compares it against
// dout. Status outputs are compared against the model every cycle.
// -----------------------------------------------------------------------------
module tb_sync_fifo_flags;

   localparam int WIDTH  = 8;
   localparam int DEPTH  = 16;
   localparam int AFULL  = DEPTH - 2;
   localparam int AEMPTY = 2;
   localparam int CW     = $clog2(DEPTH) + 1;

   // ---------------- clock / reset ----------------
   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             wr_en = 1'b0;
   logic             rd_en = 1'b0;
   logic             clr_err = 1'b0;
   logic [WIDTH-1:0] din = '0;
   logic [WIDTH-1:0] dout;
   logic             full, empty, almost_full, almost_empty;
   logic [CW-1:0]    count;
   logic             overflow, underflow;

   always #5 clk = ~clk;

   sync_fifo_flags #(
      .WIDTH(WIDTH), .DEPTH(DEPTH), .AFULL_THRESH(AFULL), .AEMPTY_THRESH(AEMPTY)
   ) dut (
      .clk(clk), .rst(rst),
      .wr_en(wr_en), .din(din),
      .rd_en(rd_en), .dout(dout),
      .full(full), .empty(empty),
      .almost_full(almost_full), .almost_empty(almost_empty),
      .count(count),
      .overflow(overflow), .underflow(underflow),
      .clr_err(clr_err)
   );

   // ---------------- counters ----------------
   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [WIDTH-1:0] m_q [$];
   logic [WIDTH-1:0] exp_q [$];
   logic             m_ovf = 1'b0;
   logic             m_udf = 1'b0;
   logic [WIDTH-1:0] m_dout = '0;
   logic             rd_pend = 1'b0;

   task automatic model_reset();
      m_q.delete();
      exp_q.delete();
      m_ovf   = 1'b0;
      m_udf   = 1'b0;
      m_dout  = '0;
      rd_pend = 1'b0;
   endtask

   always @(posedge clk) begin
      if (rst) begin
         rd_pend = 1'b0;
      end else begin
         int n;
         n = m_q.size();
         if (wr_en && n == DEPTH) m_ovf = 1'b1;
         else if (clr_err)        m_ovf = 1'b0;
         if (rd_en && n == 0)     m_udf = 1'b1;
         else if (clr_err)        m_udf = 1'b0;
         rd_pend = 1'b0;
         if (rd_en && n > 0) begin
            m_dout = m_q.pop_front();
            exp_q.push_back(m_dout);
            rd_pend = 1'b1;
         end
         if (wr_en && n < DEPTH) m_q.push_back(din);
      end
   end

   // ---------------- monitor / scoreboard ----------------
   logic [WIDTH-1:0] shown;
   always @(negedge clk) shown = dout;

   always @(posedge clk) begin
      #1;
      begin
         int n;
         logic [CW+5:0] exp_st, act_st;
         n = m_q.size();
         exp_st = {n == DEPTH, n == 0, n >= AFULL, n <= AEMPTY, m_ovf, m_udf, CW'(n)};
         act_st = {full, empty, almost_full, almost_empty, overflow, underflow, count};
         chk("status", 32'(act_st), 32'(exp_st));
         if (rd_pend) begin
            if (exp_q.size() == 0) begin
               chk("exp_q_underrun", 32'd1, 32'd0);
            end else begin
               logic [WIDTH-1:0] e;
               e = exp_q.pop_front();
`ifdef FIFO_FWFT_EN
               chk("rd_data", 32'(shown), 32'(e));
`else
               chk("rd_data", 32'(dout), 32'(e));
`endif
            end
         end
`ifdef FIFO_FWFT_EN
         if (n > 0) chk("fwft_head", 32'(dout), 32'(m_q[0]));
`else
         if (!rd_pend) chk("dout_hold", 32'(dout), 32'(m_dout));
`endif
      end
   end

   // ---------------- driver tasks ----------------
   task automatic cyc(input logic w, input logic [WIDTH-1:0] d, input logic r, input logic c = 1'b0);
      @(negedge clk);
      wr_en   = w;
      din     = d;
      rd_en   = r;
      clr_err = c;
   endtask

   task automatic idle(input int k);
      for (int i = 0; i < k; i++) cyc(1'b0, '0, 1'b0);
   endtask

   task automatic after_edge();
      @(posedge clk);
      #2;
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "bench timeout");
   end

   // ---------------- stimulus ----------------
   initial begin
      model_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_empty",  32'(empty), 32'd1);
      chk("rst_aempty", 32'(almost_empty), 32'd1);
      chk("rst_full",   32'(full), 32'd0);
      chk("rst_count",  32'(count), 32'd0);
      chk("rst_dout",   32'(dout), 32'd0);
      chk("rst_errs",   32'({overflow, underflow}), 32'd0);
      idle(2);

      // Fill and drain
      for (int i = 0; i < DEPTH; i++) begin
         cyc(1'b1, WIDTH'(i), 1'b0);
         if (i == AFULL - 1) begin
            after_edge();
            chk("afull_at_thresh", 32'(almost_full), 32'd1);
         end
      end
      after_edge();
      chk("fill_full",  32'(full), 32'd1);
      chk("fill_count", 32'(count), 32'(DEPTH));
      for (int i = 0; i < DEPTH; i++) cyc(1'b0, '0, 1'b1);
      idle(1);
      after_edge();
      chk("drain_empty", 32'(empty), 32'd1);

      // Overflow and clear
      for (int i = 0; i < DEPTH; i++) cyc(1'b1, WIDTH'(8'h10 + i), 1'b0);
      cyc(1'b1, WIDTH'(8'hAA), 1'b0);
      after_edge();
      chk("ovf_set",   32'(overflow), 32'd1);
      chk("ovf_count", 32'(count), 32'(DEPTH));
      cyc(1'b0, '0, 1'b0, 1'b1);
      after_edge();
      chk("ovf_clr", 32'(overflow), 32'd0);
      for (int i = 0; i < DEPTH; i++) cyc(1'b0, '0, 1'b1);
      idle(1);

      // Underflow with simultaneous write
      cyc(1'b1, WIDTH'(8'h55), 1'b1);
      after_edge();
      chk("udf_set",   32'(underflow), 32'd1);
      chk("udf_count", 32'(count), 32'd1);
      cyc(1'b0, '0, 1'b1);
      cyc(1'b0, '0, 1'b0, 1'b1);
      idle(1);

      // Simultaneous read/write at count 8, pointers wrap
      for (int i = 0; i < 8; i++) cyc(1'b1, WIDTH'($urandom), 1'b0);
      for (int i = 0; i < 40; i++) cyc(1'b1, WIDTH'($urandom), 1'b1);
      idle(1);
      after_edge();
      chk("simul_count", 32'(count), 32'd8);

      // Reset in the middle of operation
      for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b1);
      idle(1);
      @(negedge clk);
      #2;
      rst = 1'b1;
      model_reset();
      #1;
      chk("mid_rst_count", 32'(count), 32'd0);
      chk("mid_rst_flags", 32'({full, empty, almost_full, almost_empty}), 32'b0101);
      chk("mid_rst_errs",  32'({overflow, underflow}), 32'd0);
`ifndef FIFO_FWFT_EN
      chk("mid_rst_dout",  32'(dout), 32'd0);
`endif
      @(negedge clk);
      rst = 1'b0;
      cyc(1'b1, WIDTH'(8'h3C), 1'b0);
      cyc(1'b0, '0, 1'b1);
      idle(2);

      // Randomised traffic with phases biased toward full and toward empty
      for (int p = 0; p < 16; p++) begin
         int wp;
         wp = (p % 2 == 0) ? 80 : 25;
         for (int i = 0; i < 120; i++) begin
            cyc(1'($urandom_range(99, 0) < wp),
                WIDTH'($urandom),
                1'($urandom_range(99, 0) >= wp - 20),
                1'($urandom_range(15, 0) == 0));
         end
      end
      for (int i = 0; i < DEPTH + 2; i++) cyc(1'b0, '0, 1'b1);
      idle(3);
      chk("exp_q_drained", 32'(exp_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
